spi_regbank_slave: RTL and testbench
====================================

// Module: spi_regbank_slave
// PURPOSE
//  - Parametrised SPI slave register bank; DE0_CV top reaches it through GPIO_0 (mosi/sclk/ssn in, miso out).
//  - Each frame = HDR_W-bit header {addr, cmd, zero pad} followed by a DATA_W-bit data phase, MSB first.
//  - cmd=0 writes the data phase into the register file; cmd=1 returns the register contents on miso.
//  - A local port gives the rest of the FPGA read access to every register plus a strobe per committed write.
// PARAMETERS
//  ADDR_W      8    header address bits
//  DATA_W      16   register / data-phase width
//  HDR_W       16   header length; must be >= ADDR_W+1; pad bits ignored
//  DEPTH       256  implemented registers, 1..2**ADDR_W
//  CPOL        0    sclk idle level; 1 = internal sclk inverted (sample edge = first edge after ssn low)
//  SYNC_STAGES 2    flip-flop stages on sclk/ssn/mosi, >= 2
// PORTS
//  clk          in   1       system clock, 50 MHz
//  reset        in   1       synchronous, active-high
//  spi_sclk     in   1       async SPI clock, period >= 5 clk
//  spi_ssn      in   1       async slave select, active-low
//  spi_mosi     in   1       async serial data in
//  spi_miso     out  1       serial data out
//  spi_miso_oe  out  1       high while a read data phase is active
//  lcl_rd_addr  in   ADDR_W  local read address
//  lcl_rd_data  out  DATA_W  registered read data, 1-cycle latency
//  wr_strobe    out  1       1-cycle pulse when an SPI write commits
//  wr_addr      out  ADDR_W  address of the committed write, valid with wr_strobe
//  wr_data      out  DATA_W  data of the committed write, valid with wr_strobe
// BEHAVIOUR
//  - Reset values: all outputs 0, all registers 0, FSM = IDLE. Reset mid-frame aborts the frame with no write.
//  - Inputs pass through SYNC_STAGES flops, then a rise/fall edge detector; the sample edge is the rising edge of (sclk ^ CPOL).
//  - FSM states: IDLE, HDR, WDATA, RDATA, WAIT.
//    IDLE -> HDR on ssn falling.
//    HDR shifts mosi on each sample edge; after HDR_W bits, cmd=0 -> WDATA, cmd=1 -> RDATA.
//    At the HDR->RDATA transition, the shift register loads reg[addr] and miso drives its MSB.
//    RDATA shifts the next bit out one clk after each detected sample edge (ready before the following edge); mosi is ignored.
//    WDATA commits after DATA_W bits: reg write, plus wr_strobe/wr_addr/wr_data pulsed on the same cycle.
//    After WDATA or RDATA completes -> WAIT.
//  - WAIT -> IDLE on ssn high. Any extra sclk edges in WAIT are ignored.
//  - ssn rising in any state other than IDLE/WAIT: abort, no write, no strobe, -> IDLE, miso_oe=0.
//  - Out of range (addr >= DEPTH): write dropped and wr_strobe suppressed; read returns all zeros.
//  - spi_miso = 0 whenever spi_miso_oe = 0.
//  - Local read port is independent of SPI. On a same-cycle write commit and local read of the same address, the old value is returned.
//  - Latency: ssn/sclk edge to internal action = SYNC_STAGES+1 clk.
// CONFIGURATION
//  - SPI_REGBANK_BURST_EN defined: after a data phase, ssn held low -> no WAIT.
//    Address auto-increments, wrapping at DEPTH-1 -> 0, and another DATA_W-bit phase of the same cmd follows.
//    Each burst write pulses wr_strobe.
//  - Macro undefined: single word per frame; the FSM enters WAIT.
// STRUCTURE
//  - Package spi_regbank_pkg: typedef enum state_t {IDLE,HDR,WDATA,RDATA,WAIT}; localparams CMD_WRITE=1'b0, CMD_READ=1'b1.
//  - Sub-module spi_in_sync: SYNC_STAGES synchroniser plus edge detector for sclk/ssn/mosi.
//    Outputs sample_edge, ssn_fall, ssn_rise, mosi_s.
//  - Top level holds the FSM, bit counter ($clog2(max(HDR_W,DATA_W))+1 bits), shift register and register array.
// TESTING (sclk half-period 50 ns, clk 20 ns, 200 ns ssn guard)
//  1. Write 0xa5<-0xaa55, then read 0xa5 -> miso returns 0xaa55; exactly one wr_strobe with addr 0xa5 / data 0xaa55.
//  2. Write 0x00<-0x0000, 0x5a<-0x5678, 0xff<-0xffff; read back in reverse order -> 0xffff, 0x5678, 0x0000.
//     Afterwards lcl_rd_addr=0x5a -> lcl_rd_data=0x5678 one clk later.
//  3. DEPTH=128: write 0x80<-0x1234 -> no strobe; reg[0x00] unchanged; read 0x80 -> 0x0000.
//  4. Write 0x10<-0xbeef with ssn raised after 8 data bits -> no strobe; read 0x10 -> previous value; next frame decodes correctly.
//  5. reset asserted mid-header, then released -> outputs 0; read 0xa5 -> 0x0000.
//  6. SPI_REGBANK_BURST_EN: write 0xff burst {0x1111,0x2222} -> reg[0xff]=0x1111, reg[0x00]=0x2222, two strobes.
//     Burst read from 0xff -> 0x1111 then 0x2222.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// Shared types and helpers for the SPI register bank slave.
// Optional burst mode is selected with SPI_REGBANK_BURST_EN (see spi_regbank_slave).
package spi_regbank_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        RDATA,
        WAIT
    } state_t;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    function automatic logic addr_in_range(input int addr, input int depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchroniser and edge detector for the asynchronous SPI pins.
// sample_edge is the rising edge of (sclk ^ CPOL) after SYNC_STAGES flops.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CPOL        = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_sclk,
    input  logic spi_ssn,
    input  logic spi_mosi,
    output logic sample_edge,
    output logic ssn_fall,
    output logic ssn_rise,
    output logic mosi_s
);
    localparam logic CPOL_B = (CPOL != 0);

    logic [SYNC_STAGES-1:0] sclk_ff, ssn_ff, mosi_ff;
    logic                   sclk_prev, ssn_prev;
    logic                   sclk_s, ssn_s;

    // Reset to the idle levels so no edge is reported while the bus is quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_ff   <= {SYNC_STAGES{CPOL_B}};
            ssn_ff    <= '1;
            mosi_ff   <= '0;
            sclk_prev <= CPOL_B;
            ssn_prev  <= 1'b1;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], spi_sclk};
            ssn_ff    <= {ssn_ff[SYNC_STAGES-2:0], spi_ssn};
            mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
            ssn_prev  <= ssn_s;
        end
    end

    assign sclk_s      = sclk_ff[SYNC_STAGES-1];
    assign ssn_s       = ssn_ff[SYNC_STAGES-1];
    assign mosi_s      = mosi_ff[SYNC_STAGES-1];
    assign sample_edge = (sclk_s ^ CPOL_B) & ~(sclk_prev ^ CPOL_B);
    assign ssn_fall    = ~ssn_s & ssn_prev;
    assign ssn_rise    = ssn_s & ~ssn_prev;

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI slave register bank: header {addr, cmd, pad} then one data word (or a burst
// of words when SPI_REGBANK_BURST_EN is defined), plus a local read port.
//
// state | meaning
// IDLE  | waiting for ssn to fall
// HDR   | shifting in the header
// WDATA | shifting in write data, commit on last bit
// RDATA | shifting out register contents on miso
// WAIT  | word done, ignoring sclk until ssn rises
module spi_regbank_slave
    import spi_regbank_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int HDR_W       = 16,
    parameter int DEPTH       = 256,
    parameter int CPOL        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_ssn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [ADDR_W-1:0] lcl_rd_addr,
    output logic [DATA_W-1:0] lcl_rd_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam int CNT_W = $clog2((HDR_W > DATA_W) ? HDR_W : DATA_W) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CMD_POS   = CNT_W'(ADDR_W);

    logic sample_edge, ssn_fall, ssn_rise, mosi_s;

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .CPOL       (CPOL)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .spi_sclk   (spi_sclk),
        .spi_ssn    (spi_ssn),
        .spi_mosi   (spi_mosi),
        .sample_edge(sample_edge),
        .ssn_fall   (ssn_fall),
        .ssn_rise   (ssn_rise),
        .mosi_s     (mosi_s)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W:0]     hdr_q, hdr_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_inc, hdr_addr, rd_sel;
    logic [DATA_W-1:0]   shift_q, rd_word, wr_word;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic                shift_en, hdr_done, word_done, wr_ok;

    // Only the first ADDR_W+1 header bits are kept; pad bits leave hdr_q alone.
    assign hdr_nxt  = (cnt_q <= CMD_POS) ? {hdr_q[ADDR_W-1:0], mosi_s} : hdr_q;
    assign hdr_addr = hdr_nxt[ADDR_W:1];
    assign addr_inc = (int'(addr_q) == DEPTH - 1) ? '0 : addr_q + 1'b1;
    assign rd_sel   = hdr_done ? hdr_addr : addr_inc;
    assign rd_word  = addr_in_range(int'(rd_sel), DEPTH) ? regs[rd_sel[IDX_W-1:0]] : '0;
    assign wr_word  = {shift_q[DATA_W-2:0], mosi_s};
    assign wr_ok    = (state_q == WDATA) && word_done && addr_in_range(int'(addr_q), DEPTH);

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        hdr_done  = 1'b0;
        word_done = 1'b0;
        case (state_q)
            IDLE: if (ssn_fall) state_d = HDR;
            HDR: begin
                if (ssn_rise) begin
                    state_d = IDLE;
                end else if (sample_edge) begin
                    shift_en = 1'b1;
                    if (cnt_q == HDR_LAST) begin
                        hdr_done = 1'b1;
                        state_d  = (hdr_nxt[0] == CMD_WRITE) ? WDATA : RDATA;
                    end
                end
            end
            WDATA, RDATA: begin
                if (ssn_rise) begin
                    state_d = IDLE;
                end else if (sample_edge) begin
                    shift_en = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        word_done = 1'b1;
`ifdef SPI_REGBANK_BURST_EN
                        state_d = state_q;
`else
                        state_d = WAIT;
`endif
                    end
                end
            end
            WAIT: if (ssn_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            addr_q      <= '0;
            shift_q     <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            lcl_rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_strobe   <= 1'b0;
            lcl_rd_data <= addr_in_range(int'(lcl_rd_addr), DEPTH) ?
                           regs[lcl_rd_addr[IDX_W-1:0]] : '0;

            if (state_q == IDLE) cnt_q <= '0;
            else if (shift_en) cnt_q <= (hdr_done || word_done) ? '0 : cnt_q + 1'b1;

            if (state_q == HDR && shift_en) hdr_q <= hdr_nxt;

            if (hdr_done) addr_q <= hdr_addr;
            else if (word_done) addr_q <= addr_inc;

            // Reads preload the word so its MSB is on miso before the first data edge.
            if (hdr_done) begin
                if (hdr_nxt[0] == CMD_READ) shift_q <= rd_word;
            end else if (state_q == WDATA && shift_en) begin
                shift_q <= wr_word;
            end else if (state_q == RDATA && shift_en) begin
                shift_q <= word_done ? rd_word : {shift_q[DATA_W-2:0], 1'b0};
            end

            if (wr_ok) begin
                regs[addr_q[IDX_W-1:0]] <= wr_word;
                wr_strobe <= 1'b1;
                wr_addr   <= addr_q;
                wr_data   <= wr_word;
            end
        end
    end

    assign spi_miso_oe = (state_q == RDATA);
    assign spi_miso    = spi_miso_oe & shift_q[DATA_W-1];

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Bench for spi_regbank_slave: a DEPTH=256 and a DEPTH=128 instance share one SPI bus;
// a frame-level register model predicts strobes, miso words and the local read port.
module tb_spi_regbank_slave;

`ifdef SPI_REGBANK_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        sclk = 1'b0, ssn = 1'b1, mosi = 1'b0;
    logic [7:0]  lcl_rd_addr = '0;
    logic        miso_a, oe_a, strobe_a, miso_b, oe_b, strobe_b;
    logic [15:0] lcl_a, lcl_b, wdata_a, wdata_b;
    logic [7:0]  waddr_a, waddr_b;

    int n_vec = 0, n_err = 0;
    int n_strobe_a = 0, n_strobe_b = 0;
    logic rst_q = 1'b1;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         qa[$], qb[$];
    wr_t         ea, eb;
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] exp_lcl_a = '0, exp_lcl_b = '0;
    logic        lcl_hold = 1'b0;
    logic [7:0]  lcl_hold_addr = '0;

    spi_regbank_slave #(.DEPTH(256)) dut_a (
        .clk(clk), .reset(reset), .spi_sclk(sclk), .spi_ssn(ssn), .spi_mosi(mosi),
        .spi_miso(miso_a), .spi_miso_oe(oe_a), .lcl_rd_addr(lcl_rd_addr), .lcl_rd_data(lcl_a),
        .wr_strobe(strobe_a), .wr_addr(waddr_a), .wr_data(wdata_a)
    );

    spi_regbank_slave #(.DEPTH(128)) dut_b (
        .clk(clk), .reset(reset), .spi_sclk(sclk), .spi_ssn(ssn), .spi_mosi(mosi),
        .spi_miso(miso_b), .spi_miso_oe(oe_b), .lcl_rd_addr(lcl_rd_addr), .lcl_rd_data(lcl_b),
        .wr_strobe(strobe_b), .wr_addr(waddr_b), .wr_data(wdata_b)
    );

    always #10 clk = ~clk;
    always @(posedge clk) rst_q <= reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle checks; the register model only changes when a predicted write is seen.
    always @(negedge clk) begin
        if (rst_q) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] = '0;
                mem_b[i] = '0;
            end
            qa.delete();
            qb.delete();
            chk("rst_lcl_a", lcl_a, 0);
            chk("rst_strobe_a", strobe_a, 0);
            chk("rst_oe_b", oe_b, 0);
        end else begin
            chk("lcl_a", lcl_a, exp_lcl_a);
            chk("lcl_b", lcl_b, exp_lcl_b);
            if (!oe_a) chk("miso_gate_a", miso_a, 0);
            if (!oe_b) chk("miso_gate_b", miso_b, 0);
            if (strobe_a) begin
                n_strobe_a++;
                chk("strobe_predicted_a", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    chk("wr_addr_a", waddr_a, ea.addr);
                    chk("wr_data_a", wdata_a, ea.data);
                    mem_a[ea.addr] = ea.data;
                end
            end
            if (strobe_b) begin
                n_strobe_b++;
                chk("strobe_predicted_b", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    chk("wr_addr_b", waddr_b, eb.addr);
                    chk("wr_data_b", wdata_b, eb.data);
                    mem_b[eb.addr] = eb.data;
                end
            end
        end
        lcl_rd_addr = lcl_hold ? lcl_hold_addr : lcl_rd_addr + 8'd1;
        exp_lcl_a   = mem_a[lcl_rd_addr];
        exp_lcl_b   = (lcl_rd_addr < 8'd128) ? mem_b[lcl_rd_addr] : 16'h0000;
    end

    // One SPI frame: header, then data_bits clocks. wdat holds up to two words, MSB first.
    task automatic xfer(input logic cmd, input logic [7:0] addr, input int nwords,
                        input int data_bits, input logic [31:0] wdat,
                        output logic [31:0] rda, output logic [31:0] rdb);
        logic [15:0] hdr;
        logic [31:0] expa, expb;
        logic [7:0]  aa, ab;
        hdr  = {addr, cmd, 7'b0};
        aa   = addr;
        ab   = addr;
        expa = '0;
        expb = '0;
        rda  = '0;
        rdb  = '0;
        for (int i = 0; i < nwords; i++) begin
            logic [15:0] w;
            w = (i == 0) ? wdat[31:16] : wdat[15:0];
            if (i == 0 || BURST) begin
                if (!cmd && data_bits >= 16 * (i + 1)) begin
                    qa.push_back('{aa, w});
                    if (ab < 8'd128) qb.push_back('{ab, w});
                end
                if (cmd) begin
                    expa[31-16*i -: 16] = mem_a[aa];
                    expb[31-16*i -: 16] = (ab < 8'd128) ? mem_b[ab] : 16'h0000;
                end
            end
            aa = aa + 8'd1;
            ab = (ab == 8'd127) ? 8'd0 : ab + 8'd1;
        end

        @(negedge clk);
        #3;
        ssn = 1'b0;
        #100;
        for (int j = 0; j < 16 + data_bits; j++) begin
            mosi = (j < 16) ? hdr[15-j] : (cmd ? 1'b0 : wdat[31-(j-16)]);
            #50;
            sclk = 1'b1;
            if (j >= 16) begin
                rda[31-(j-16)] = miso_a;
                rdb[31-(j-16)] = miso_b;
            end
            #50;
            sclk = 1'b0;
        end
        #100;
        ssn  = 1'b1;
        mosi = 1'b0;
        #200;

        if (cmd) begin
            for (int i = 0; i < nwords; i++) begin
                if (data_bits >= 16 * (i + 1)) begin
                    chk($sformatf("rd_a_%02h_w%0d", addr, i), rda[31-16*i -: 16], expa[31-16*i -: 16]);
                    chk($sformatf("rd_b_%02h_w%0d", addr, i), rdb[31-16*i -: 16], expb[31-16*i -: 16]);
                end
            end
        end
        chk("pending_wr_a", qa.size(), 0);
        chk("pending_wr_b", qb.size(), 0);
    endtask

    initial begin
        #1ms;
        n_err++;
        $display("FAIL watchdog: time limit reached, got %0t expected < 1ms", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int sa, sb;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("init_waddr_a", waddr_a, 0);
        chk("init_oe_a", oe_a, 0);

        // 1: single write then read back
        sa = n_strobe_a; sb = n_strobe_b;
        xfer(1'b0, 8'ha5, 1, 16, {16'haa55, 16'h0}, ra, rb);
        chk("t1_strobes_a", n_strobe_a - sa, 1);
        chk("t1_strobes_b", n_strobe_b - sb, 0);
        xfer(1'b1, 8'ha5, 1, 16, '0, ra, rb);
        chk("t1_read_a", ra[31:16], 16'haa55);
        chk("t1_read_b", rb[31:16], 16'h0000);

        // 2: boundary addresses, reverse-order readback, local port
        xfer(1'b0, 8'h00, 1, 16, {16'h0000, 16'h0}, ra, rb);
        xfer(1'b0, 8'h5a, 1, 16, {16'h5678, 16'h0}, ra, rb);
        xfer(1'b0, 8'hff, 1, 16, {16'hffff, 16'h0}, ra, rb);
        xfer(1'b1, 8'hff, 1, 16, '0, ra, rb);
        chk("t2_read_ff", ra[31:16], 16'hffff);
        xfer(1'b1, 8'h5a, 1, 16, '0, ra, rb);
        chk("t2_read_5a", ra[31:16], 16'h5678);
        xfer(1'b1, 8'h00, 1, 16, '0, ra, rb);
        chk("t2_read_00", ra[31:16], 16'h0000);
        lcl_hold_addr = 8'h5a;
        lcl_hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_lcl_5a", lcl_a, 16'h5678);
        lcl_hold = 1'b0;

        // 3: out-of-range write on the 128-deep instance
        xfer(1'b0, 8'h00, 1, 16, {16'h0c0c, 16'h0}, ra, rb);
        sa = n_strobe_a; sb = n_strobe_b;
        xfer(1'b0, 8'h80, 1, 16, {16'h1234, 16'h0}, ra, rb);
        chk("t3_strobes_a", n_strobe_a - sa, 1);
        chk("t3_strobes_b", n_strobe_b - sb, 0);
        xfer(1'b1, 8'h00, 1, 16, '0, ra, rb);
        chk("t3_read_00_b", rb[31:16], 16'h0c0c);
        xfer(1'b1, 8'h80, 1, 16, '0, ra, rb);
        chk("t3_read_80_a", ra[31:16], 16'h1234);
        chk("t3_read_80_b", rb[31:16], 16'h0000);

        // 4: write aborted after 8 data bits
        xfer(1'b0, 8'h10, 1, 16, {16'h1357, 16'h0}, ra, rb);
        sa = n_strobe_a; sb = n_strobe_b;
        xfer(1'b0, 8'h10, 1, 8, {16'hbeef, 16'h0}, ra, rb);
        chk("t4_strobes_a", n_strobe_a - sa, 0);
        chk("t4_strobes_b", n_strobe_b - sb, 0);
        xfer(1'b1, 8'h10, 1, 16, '0, ra, rb);
        chk("t4_read_10", ra[31:16], 16'h1357);
        xfer(1'b0, 8'h11, 1, 16, {16'h2468, 16'h0}, ra, rb);
        xfer(1'b1, 8'h11, 1, 16, '0, ra, rb);
        chk("t4_read_11", ra[31:16], 16'h2468);

        // 5: reset in the middle of a header
        @(negedge clk);
        #3;
        ssn = 1'b0;
        #100;
        for (int j = 0; j < 8; j++) begin
            mosi = j[0];
            #50; sclk = 1'b1;
            #50; sclk = 1'b0;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_lcl_a", lcl_a, 0);
        chk("t5_oe_a", oe_a, 0);
        chk("t5_miso_a", miso_a, 0);
        chk("t5_waddr_a", waddr_a, 0);
        chk("t5_wdata_a", wdata_a, 0);
        ssn  = 1'b1;
        mosi = 1'b0;
        #200;
        xfer(1'b1, 8'ha5, 1, 16, '0, ra, rb);
        chk("t5_read_a5", ra[31:16], 16'h0000);

        // 6: two-word frame across the top address
        xfer(1'b0, 8'h00, 1, 16, {16'habcd, 16'h0}, ra, rb);
        sa = n_strobe_a; sb = n_strobe_b;
        xfer(1'b0, 8'hff, 2, 32, {16'h1111, 16'h2222}, ra, rb);
        xfer(1'b1, 8'hff, 2, 32, '0, ra, rb);
        chk("t6_read_ff_w0", ra[31:16], 16'h1111);
`ifdef SPI_REGBANK_BURST_EN
        chk("t6_strobes_a", n_strobe_a - sa, 2);
        chk("t6_strobes_b", n_strobe_b - sb, 1);
        chk("t6_read_ff_w1", ra[15:0], 16'h2222);
        chk("t6_read_b_w1", rb[15:0], 16'h2222);
`else
        chk("t6_strobes_a", n_strobe_a - sa, 1);
        chk("t6_strobes_b", n_strobe_b - sb, 0);
        chk("t6_read_ff_w1", ra[15:0], 16'h0000);
`endif
        xfer(1'b1, 8'h00, 1, 16, '0, ra, rb);
        chk("t6_read_00", ra[31:16], BURST ? 16'h2222 : 16'habcd);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
